// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory side of the core: memory size,
// end-of-program marker and the program loader's state encoding.
package mips_pkg;

    // Shared with the instruction memory and the PC wrap logic.
    localparam int          INSMEM_BYTES     = 256;
    localparam int          INSMEM_ADDR_W    = $clog2(INSMEM_BYTES);
    localparam logic [31:0] LOADER_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHK   = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/insmem_loader_if.sv
// Loader bus: UART byte stream and debug start in, memory write port and status out.
// master = debug unit / UART / memory side, slave = the loader.
interface insmem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              write_en;
    logic [31:0]       data;
    logic [ADDR_W-1:0] addr_wr;
    logic              busy;
    logic              done;
    logic              full;
    logic              chk_err;

    modport master (
        output start, rx_data, rx_valid,
        input  write_en, data, addr_wr, busy, done, full, chk_err
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output write_en, data, addr_wr, busy, done, full, chk_err
    );
endinterface

// File: rtl/insmem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; o_word_ready flags the
// cycle in which the 4th byte is on i_rx_data, with the complete word on o_word.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic [31:0] o_word,
    output logic        o_word_ready
);
    logic [23:0] r_lanes;
    logic [1:0]  r_byte_cnt;
    logic        w_take;

    assign w_take       = i_enable && i_rx_valid;
    assign o_word_ready = w_take && (r_byte_cnt == 2'd3);
    assign o_word       = {i_rx_data, r_lanes};

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_lanes    <= '0;
            r_byte_cnt <= '0;
        end else if (w_take) begin
            case (r_byte_cnt)
                2'd0:    r_lanes[7:0]   <= i_rx_data;
                2'd1:    r_lanes[15:8]  <= i_rx_data;
                2'd2:    r_lanes[23:16] <= i_rx_data;
                default: ;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/insmem_loader.sv
// Program loader: UART bytes -> 32-bit words -> instruction memory write port.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module insmem_loader
    import mips_pkg::*;
#(
    parameter int          MEM_BYTES = INSMEM_BYTES,
    parameter int          ADDR_W    = INSMEM_ADDR_W,
    parameter logic [31:0] HALT_WORD = LOADER_HALT_WORD
) (
    input  logic           clk,
    input  logic           reset,
    insmem_loader_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

    loader_state_t     r_state;
    logic              r_write_en;
    logic [31:0]       r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_full;

    logic              w_start;
    logic              w_accept;
    logic [31:0]       w_word;
    logic              w_word_ready;

    assign w_start  = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
    // A byte landing in the WRITE cycle already belongs to the next word.
    assign w_accept = (r_state == ST_RECV) || (r_state == ST_WRITE);

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start),
        .i_enable     (w_accept),
        .i_rx_valid   (bus.rx_valid),
        .i_rx_data    (bus.rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_write_en <= 1'b0;
            r_data     <= '0;
            r_addr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state <= ST_RECV;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_full  <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (w_word_ready) begin
                        r_data     <= w_word;
                        r_write_en <= 1'b1;
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_data == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= ST_CHK;
`else
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else if (r_addr == LAST_ADDR) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_full  <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(4);
                        r_state <= ST_RECV;
                    end
                end
                ST_CHK: begin
                    if (bus.rx_valid) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_chk_err;

    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_csum    <= '0;
            r_chk_err <= 1'b0;
        end else if (w_accept && bus.rx_valid) begin
            r_csum <= r_csum ^ bus.rx_data;
        end else if (r_state == ST_CHK && bus.rx_valid) begin
            r_chk_err <= (bus.rx_data != r_csum);
        end
    end

    assign bus.chk_err = r_chk_err;
`else
    assign bus.chk_err = 1'b0;
`endif

    assign bus.write_en = r_write_en;
    assign bus.data     = r_data;
    assign bus.addr_wr  = r_addr;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.full     = r_full;
endmodule

// File: tb/tb_insmem_loader.sv
// Randomized scoreboard bench for insmem_loader; the byte-level program model
// predicts every memory write and the final status flags.
module tb_insmem_loader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    insmem_loader_if #(.ADDR_W(8)) bus ();

    insmem_loader #(
        .MEM_BYTES (256),
        .ADDR_W    (8),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb_q[$];

    typedef enum {M_IDLE, M_LOAD, M_CHK, M_DONE} mstate_t;
    mstate_t     m_st;
    int          m_addr;
    int          m_cnt;
    logic [31:0] m_word;
    logic [7:0]  m_csum;
    bit          m_full;
    bit          m_chk_err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    logic [31:0] last_data;
    logic [7:0]  last_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest predicted write.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.busy && bus.done)
                check("busy_and_done", 1, 0);
            if (bus.write_en) begin
                n_writes++;
                last_data = bus.data;
                last_addr = bus.addr_wr;
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", bus.addr_wr, e.addr);
                    check("wr_data", bus.data, e.data);
                end
            end
        end
    end

    task automatic model_byte(input logic [7:0] b, output bit ended);
        ended = 1'b0;
        case (m_st)
            M_LOAD: begin
                m_word[8*m_cnt +: 8] = b;
                m_csum = m_csum ^ b;
                m_cnt++;
                if (m_cnt == 4) begin
                    m_cnt = 0;
                    sb_q.push_back('{addr: m_addr[7:0], data: m_word});
                    if (m_word == HALT) begin
                        m_st  = CHK_EN ? M_CHK : M_DONE;
                        ended = 1'b1;
                    end else if (m_addr == 252) begin
                        m_st   = M_DONE;
                        m_full = 1'b1;
                        ended  = 1'b1;
                    end else begin
                        m_addr += 4;
                    end
                end
            end
            M_CHK: begin
                m_chk_err = (b != m_csum);
                m_st      = M_DONE;
            end
            default: ;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ended;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        model_byte(b, ended);
        if (ended) begin
            @(posedge clk); #1;
        end
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], $urandom_range(gap_max, 0));
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (m_st == M_IDLE || m_st == M_DONE) begin
            m_st      = M_LOAD;
            m_addr    = 0;
            m_cnt     = 0;
            m_csum    = '0;
            m_full    = 1'b0;
            m_chk_err = 1'b0;
        end
    endtask

    task automatic check_status(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_busy"}, bus.busy, (m_st == M_LOAD || m_st == M_CHK));
        check({tag, "_done"}, bus.done, (m_st == M_DONE));
        check({tag, "_full"}, bus.full, m_full);
        check({tag, "_chk_err"}, bus.chk_err, m_chk_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_write_en"}, bus.write_en, 0);
        check({tag, "_data"}, bus.data, 0);
        check({tag, "_addr"}, bus.addr_wr, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_chk_err"}, bus.chk_err, 0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w[0] = 1'b0;
        return w;
    endfunction

    task automatic finish_checksum(input bit corrupt);
        if (CHK_EN) begin
            check_status("pre_chk");
            send_byte(corrupt ? (m_csum ^ 8'h5A) : m_csum, 1);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        m_st = M_IDLE; m_addr = 0; m_cnt = 0; m_word = '0; m_csum = '0;
        m_full = 1'b0; m_chk_err = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Bytes in IDLE are ignored.
        send_byte(8'hAB, 0);
        check_status("idle_ignore");

        // Directed: first word, then a 3-word program ending in HALT.
        do_start();
        send_byte(8'h13, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h20, 0);
        check_status("t1");
        check("t1_data", last_data, 32'h2000_0013);
        check("t1_addr", last_addr, 0);
        send_word(32'h1122_3344, 0);
        send_word(32'hAABB_CCDD, 2);
        send_word(HALT, 0);
        finish_checksum(1'b0);
        check_status("t2");
        check("t2_writes", n_writes, 4);
        check("t2_last_addr", last_addr, 12);

        // Fill memory with 64 non-HALT words; further bytes must not write.
        do_start();
        w0 = n_writes;
        for (int i = 0; i < 64; i++) send_word(rand_word(), 2);
        check("t3_writes", n_writes - w0, 64);
        check("t3_last_addr", last_addr, 252);
        send_word(rand_word(), 1);
        check_status("t3");
        check("t3_no_extra", n_writes - w0, 64);

        // Random programs, back-to-back bytes included, with ignored mid-load starts.
        for (int it = 0; it < 8; it++) begin
            int nw;
            nw = $urandom_range(12, 1);
            do_start();
            for (int i = 0; i < nw; i++) begin
                send_word(rand_word(), $urandom_range(2, 0));
                if (i == 0) do_start();
            end
            send_word(HALT, $urandom_range(1, 0));
            finish_checksum(it[0]);
            check_status("rand");
        end

        // Reset mid-load after 2 bytes of word 3, then reload from address 0.
        do_start();
        send_word(rand_word(), 0);
        send_word(rand_word(), 1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_reset");
        reset = 1'b0;
        m_st = M_IDLE; m_cnt = 0; m_full = 1'b0; m_chk_err = 1'b0;
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        check_status("post_reset_idle");
        do_start();
        send_word(32'hDEAD_BEEF, 0);
        send_word(HALT, 0);
        finish_checksum(1'b0);
        check_status("reload");
        check("reload_last_addr", last_addr, 4);
        check("reload_last_data", last_data, HALT);

        repeat (4) @(posedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
